sr_pulse_ctrl: RTL and testbench

- Upstream driver for the NOR set/reset latch.
- Takes two raw, bouncy push-button inputs and synchronizes and debounces each one.
- Converts each debounced press into a clean, fixed-width active-high pulse on `set` or `reset`.
- Guarantees `set` and `reset` are never high together, and inserts a one-cycle all-low gap between successive pulses so the latch always sees a legal input sequence.

---
 rtl/sr_ctrl_pkg.sv | 15 +
 rtl/debounce_ch.sv | 53 +++++
 rtl/sr_pulse_ctrl.sv | 130 +++++++++++++
 tb/tb_sr_pulse_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the NOR-latch pulse controller: FSM encoding and
// default timing constants.
package sr_ctrl_pkg;

  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_PULSE_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE_S = 2'd1,
    ST_PULSE_R = 2'd2,
    ST_GAP     = 2'd3
  } sr_state_e;

endpackage

// File: rtl/debounce_ch.sv
// One button channel: two-flop synchronizer, stability-counter debouncer and
// rising-edge detector on the debounced level.
module debounce_ch
  import sr_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;

  logic          s1_r;
  logic          s2_r;
  logic          deb_r;
  logic          deb_d_r;
  logic [CW-1:0] cnt_r;

  // Synchronizer and previous-level history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r    <= 1'b0;
      s2_r    <= 1'b0;
      deb_d_r <= 1'b0;
    end else begin
      s1_r    <= btn;
      s2_r    <= s1_r;
      deb_d_r <= deb_r;
    end
  end

  // Accept a new level only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_r <= 1'b0;
      cnt_r <= {CW{1'b0}};
    end else if (s2_r == deb_r) begin
      cnt_r <= {CW{1'b0}};
    end else if (cnt_r == CW'(DEB_CYCLES - 1)) begin
      deb_r <= s2_r;
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Only presses matter; releases produce nothing
  assign rise = deb_r & ~deb_d_r;

endmodule

// File: rtl/sr_pulse_ctrl.sv
// Turns two bouncy buttons into mutually exclusive, fixed-width set/reset
// pulses for a NOR latch, with an all-low gap between consecutive pulses.
module sr_pulse_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int PULSE_W    = DEF_PULSE_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set,
  input  logic btn_rst,
  output logic set,
  output logic reset,
  output logic busy
);

  localparam int PCW = $clog2(PULSE_W) + 1;

  logic           req_set_s;
  logic           req_rst_s;
  logic           want_rst_s;
  logic           want_set_s;
  logic           start_rst_s;
  logic           start_set_s;
  logic           pend_set_nx_s;
  logic           pend_rst_nx_s;
  logic           busy_nx_s;
  logic           pulse_last_s;

  sr_state_e      state_r;
  logic [PCW-1:0] pcnt_r;
  logic           pend_set_r;
  logic           pend_rst_r;
  logic           set_r;
  logic           reset_r;
  logic           busy_r;

  debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_set),
    .rise  (req_set_s)
  );

  debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_rst),
    .rise  (req_rst_s)
  );

  // Arbitration from IDLE (reset wins) and next values of pending/busy
  always_comb begin
    want_rst_s    = pend_rst_r | req_rst_s;
    want_set_s    = pend_set_r | req_set_s;
    start_rst_s   = (state_r == ST_IDLE) & want_rst_s;
    start_set_s   = (state_r == ST_IDLE) & ~want_rst_s & want_set_s;
    pend_rst_nx_s = start_rst_s ? 1'b0 : want_rst_s;
    pend_set_nx_s = start_set_s ? 1'b0 : want_set_s;
    pulse_last_s  = (pcnt_r == PCW'(PULSE_W - 1));
    busy_nx_s     = start_rst_s | start_set_s
                  | (state_r == ST_PULSE_S) | (state_r == ST_PULSE_R)
                  | pend_rst_nx_s | pend_set_nx_s;
  end

  // One-deep request memory per channel plus registered busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_set_r <= 1'b0;
      pend_rst_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      pend_set_r <= pend_set_nx_s;
      pend_rst_r <= pend_rst_nx_s;
      busy_r     <= busy_nx_s;
    end
  end

  // Pulse sequencer; outputs are registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      pcnt_r  <= {PCW{1'b0}};
      set_r   <= 1'b0;
      reset_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          pcnt_r <= {PCW{1'b0}};
          if (start_rst_s) begin
            state_r <= ST_PULSE_R;
            reset_r <= 1'b1;
          end else if (start_set_s) begin
            state_r <= ST_PULSE_S;
            set_r   <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_PULSE_S, ST_PULSE_R: begin
          if (pulse_last_s) begin
            state_r <= ST_GAP;
            pcnt_r  <= {PCW{1'b0}};
            set_r   <= 1'b0;
            reset_r <= 1'b0;
          end else begin
            pcnt_r  <= pcnt_r + PCW'(1);
          end
        end
        ST_GAP: begin
          state_r <= ST_IDLE;
          set_r   <= 1'b0;
          reset_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          pcnt_r  <= {PCW{1'b0}};
          set_r   <= 1'b0;
          reset_r <= 1'b0;
        end
      endcase
    end
  end

  assign set   = set_r;
  assign reset = reset_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_sr_pulse_ctrl.sv
// Directed bench for sr_pulse_ctrl: table of per-cycle button patterns with
// expected pulse timing, plus sequences for reset behaviour.
module tb_sr_pulse_ctrl;

  logic clk;
  logic rst_n;
  logic btn_set;
  logic btn_rst;
  logic set;
  logic reset;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;

  sr_pulse_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_set (btn_set),
    .btn_rst (btn_rst),
    .set     (set),
    .reset   (reset),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bit k of a pattern is the button level driven just after edge k
  typedef struct {
    string       name;
    logic [31:0] pat_s;
    logic [31:0] pat_r;
    int          s_first;
    int          r_first;
    int          s_n;
    int          r_n;
  } vec_t;

  localparam int NV  = 10;
  localparam int WIN = 40;
  vec_t vecs [NV];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    btn_set = 1'b0;
    btn_rst = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int s_first = -1;
    int r_first = -1;
    int s_n = 0, r_n = 0, s_hi = 0, r_hi = 0, ovl = 0;
    logic ps = 1'b0;
    logic pr = 1'b0;
    apply_reset();
    @(posedge clk);
    #1;
    btn_set = v.pat_s[0];
    btn_rst = v.pat_r[0];
    for (int k = 1; k <= WIN; k++) begin
      int kk;
      kk = (k > 31) ? 31 : k;
      @(posedge clk);
      #1;
      btn_set = v.pat_s[kk];
      btn_rst = v.pat_r[kk];
      @(negedge clk);
      if (set && !ps) begin
        s_n++;
        if (s_first < 0) s_first = k;
      end
      if (reset && !pr) begin
        r_n++;
        if (r_first < 0) r_first = k;
      end
      if (set) s_hi++;
      if (reset) r_hi++;
      if (set && reset) ovl++;
      ps = set;
      pr = reset;
    end
    chk({v.name, " set_rise_edge"}, s_first, v.s_first);
    chk({v.name, " reset_rise_edge"}, r_first, v.r_first);
    chk({v.name, " set_pulses"}, s_n, v.s_n);
    chk({v.name, " reset_pulses"}, r_n, v.r_n);
    chk({v.name, " set_high_cycles"}, s_hi, 2 * v.s_n);
    chk({v.name, " reset_high_cycles"}, r_hi, 2 * v.r_n);
    chk({v.name, " overlap_cycles"}, ovl, 0);
    chk({v.name, " busy_at_end"}, int'(busy), 0);
  endtask

  // Drive a few idle cycles and count any pulse that appears
  task automatic quiet_window(input string name, input int cycles);
    int pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (set || reset) pulses++;
    end
    chk(name, pulses, 0);
  endtask

  initial begin
    vecs[0] = '{"clean_set",    32'hFFFF_FFFF, 32'h0000_0000,  7, -1, 1, 0};
    vecs[1] = '{"clean_rst",    32'h0000_0000, 32'hFFFF_FFFF, -1,  7, 0, 1};
    vecs[2] = '{"simultaneous", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 11,  7, 1, 1};
    vecs[3] = '{"set_in_pulse", 32'hFFFF_FFFC, 32'hFFFF_FFFF, 11,  7, 1, 1};
    vecs[4] = '{"rst_in_gap",   32'hFFFF_FFFF, 32'hFFFF_FFF8,  7, 11, 1, 1};
    vecs[5] = '{"set_in_idle",  32'hFFFF_FFF0, 32'hFFFF_FFFF, 11,  7, 1, 1};
    vecs[6] = '{"set_late",     32'hFFFF_FFE0, 32'hFFFF_FFFF, 12,  7, 1, 1};
    vecs[7] = '{"short3",       32'h0000_0007, 32'h0000_0000, -1, -1, 0, 0};
    vecs[8] = '{"short4",       32'h0000_000F, 32'h0000_0000,  7, -1, 1, 0};
    vecs[9] = '{"bounce",       32'hFFFF_FFF5, 32'h0000_0000, 11, -1, 1, 0};

    btn_set = 1'b0;
    btn_rst = 1'b0;
    rst_n   = 1'b0;

    // Outputs stay low while reset is held, regardless of buttons
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      btn_set = k[0];
      btn_rst = ~k[1];
      @(negedge clk);
      chk("reset_hold_outputs", int'({set, reset, busy}), 0);
    end

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a set pulse
    apply_reset();
    @(posedge clk);
    #1;
    btn_set = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("midpulse_set_before", int'(set), 1);
    chk("midpulse_busy_before", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midpulse_set_async_low", int'(set), 0);
    chk("midpulse_busy_async_low", int'(busy), 0);
    btn_set = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    quiet_window("midpulse_no_pulse_after", 20);

    // Reset during the reset pulse discards the pending set request
    apply_reset();
    @(posedge clk);
    #1;
    btn_set = 1'b1;
    btn_rst = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("pendlost_reset_before", int'(reset), 1);
    chk("pendlost_set_before", int'(set), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("pendlost_reset_async_low", int'(reset), 0);
    btn_set = 1'b0;
    btn_rst = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    quiet_window("pendlost_no_pulse_after", 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
